// File: rtl/cntr_mod_if.sv
// Control/status bundle for cntr_mod: master drives the controls and load value,
// slave returns the count, the terminal-count pulse and the zero flag.
interface cntr_mod_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             zero;

    modport master (output en, up, clr, load, load_val, input q, tc, zero);
    modport slave  (input en, up, clr, load, load_val, output q, tc, zero);
endinterface

// File: rtl/cntr_mod.sv
// Modulo up/down counter with prescaler, sync clear/load (clamped) and registered tc pulse.
// Define CNTR_MOD_SAT_EN to saturate at the limits instead of wrapping.
module cntr_mod #(
    parameter int WIDTH    = 16,
    parameter int MODULUS  = 65536,
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       reset,
    cntr_mod_if.slave  bus
);
    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

`ifdef CNTR_MOD_SAT_EN
    localparam logic [WIDTH-1:0] LP_UP_BND = LP_MAX;
    localparam logic [WIDTH-1:0] LP_DN_BND = '0;
`else
    localparam logic [WIDTH-1:0] LP_UP_BND = '0;
    localparam logic [WIDTH-1:0] LP_DN_BND = LP_MAX;
`endif

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_ld_val;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             w_tick;
    logic             w_restart;

    // clr and load both realign the prescaler phase
    assign w_restart = bus.clr | bus.load;

    generate
        if (PRESCALE > 1) begin : g_pre
            localparam int              PW          = $clog2(PRESCALE);
            localparam logic [PW-1:0]   LP_PRE_LAST = PW'(PRESCALE - 1);
            logic [PW-1:0] r_pre;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    r_pre <= '0;
                else if (w_restart)
                    r_pre <= '0;
                else if (bus.en)
                    r_pre <= (r_pre == LP_PRE_LAST) ? '0 : r_pre + PW'(1);
            end

            assign w_tick = bus.en & (r_pre == LP_PRE_LAST);
        end else begin : g_nopre
            assign w_tick = bus.en;
        end
    endgenerate

    // out-of-range loads clamp to the top of the range rather than wrapping
    assign w_ld_val = (bus.load_val > LP_MAX) ? LP_MAX : bus.load_val;

    always_comb begin
        w_q_nxt  = r_q;
        w_tc_nxt = 1'b0;
        if (bus.clr) begin
            w_q_nxt = '0;
        end else if (bus.load) begin
            w_q_nxt = w_ld_val;
        end else if (w_tick) begin
            if (bus.up) begin
                if (r_q == LP_MAX) begin
                    w_q_nxt  = LP_UP_BND;
                    w_tc_nxt = 1'b1;
                end else begin
                    w_q_nxt = r_q + WIDTH'(1);
                end
            end else begin
                if (r_q == '0) begin
                    w_q_nxt  = LP_DN_BND;
                    w_tc_nxt = 1'b1;
                end else begin
                    w_q_nxt = r_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q  <= '0;
            r_tc <= 1'b0;
        end else begin
            r_q  <= w_q_nxt;
            r_tc <= w_tc_nxt;
        end
    end

    assign bus.q    = r_q;
    assign bus.tc   = r_tc;
    assign bus.zero = (r_q == '0);
endmodule
